// File: rtl/seven_segment_sink.sv
// Pin-side sink for the seven-segment annode/cathode streams: pairs one word from each,
// blanks all pins for DEADTIME_CYCLES, then applies. Optional macro SEVEN_SEGMENT_SINK_SKIP_SAME_EN.
//
//   state   | meaning
//   --------+----------------------------------------------------------
//   COLLECT | accepting words; pins show the last applied pair
//   BLANK   | pair held, pins forced dark until cnt_q reaches zero
module seven_segment_sink #(
  parameter int AN_WIDTH        = 8,
  parameter int CAT_WIDTH       = 8,
  parameter int DEADTIME_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          input_annode,
  input  logic                 input_annode_stb,
  output logic                 input_annode_ack,
  input  logic [31:0]          input_cathode,
  input  logic                 input_cathode_stb,
  output logic                 input_cathode_ack,
  output logic [AN_WIDTH-1:0]  annode_pins,
  output logic [CAT_WIDTH-1:0] cathode_pins,
  output logic [15:0]          frame_count
);

  typedef enum logic [0:0] {COLLECT, BLANK} state_t;

  localparam logic [15:0] DT_LOAD = 16'((DEADTIME_CYCLES > 0) ? DEADTIME_CYCLES - 1 : 0);

  state_t               state_q;
  logic [AN_WIDTH-1:0]  an_buf_q, an_buf_d;
  logic [CAT_WIDTH-1:0] cat_buf_q, cat_buf_d;
  logic                 have_an_q, have_cat_q;
  logic [15:0]          cnt_q;
  logic                 an_xfer, cat_xfer, pair_done;
  logic                 unused_upper_bits;

  // Only the low pin-width bits of each word reach the board.
  assign unused_upper_bits = ^{input_annode, input_cathode};

  assign input_annode_ack  = rst && (state_q == COLLECT) && !have_an_q;
  assign input_cathode_ack = rst && (state_q == COLLECT) && !have_cat_q;

  always_comb begin
    an_xfer   = input_annode_stb && input_annode_ack;
    cat_xfer  = input_cathode_stb && input_cathode_ack;
    an_buf_d  = an_xfer  ? input_annode[AN_WIDTH-1:0]   : an_buf_q;
    cat_buf_d = cat_xfer ? input_cathode[CAT_WIDTH-1:0] : cat_buf_q;
    pair_done = (have_an_q || an_xfer) && (have_cat_q || cat_xfer);
  end

`ifdef SEVEN_SEGMENT_SINK_SKIP_SAME_EN
  logic same_pair;
  assign same_pair = (an_buf_d == annode_pins) && (cat_buf_d == cathode_pins);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= COLLECT;
      an_buf_q     <= '0;
      cat_buf_q    <= '0;
      have_an_q    <= 1'b0;
      have_cat_q   <= 1'b0;
      cnt_q        <= '0;
      annode_pins  <= '1;
      cathode_pins <= '1;
      frame_count  <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          an_buf_q   <= an_buf_d;
          cat_buf_q  <= cat_buf_d;
          have_an_q  <= have_an_q || an_xfer;
          have_cat_q <= have_cat_q || cat_xfer;
          if (pair_done) begin
`ifdef SEVEN_SEGMENT_SINK_SKIP_SAME_EN
            if (same_pair) begin
              have_an_q  <= 1'b0;
              have_cat_q <= 1'b0;
            end else
`endif
            if (DEADTIME_CYCLES == 0) begin
              annode_pins  <= an_buf_d;
              cathode_pins <= cat_buf_d;
              have_an_q    <= 1'b0;
              have_cat_q   <= 1'b0;
              frame_count  <= frame_count + 16'd1;
            end else begin
              state_q      <= BLANK;
              annode_pins  <= '1;
              cathode_pins <= '1;
              cnt_q        <= DT_LOAD;
            end
          end
        end
        BLANK: begin
          if (cnt_q == 16'd0) begin
            annode_pins  <= an_buf_q;
            cathode_pins <= cat_buf_q;
            have_an_q    <= 1'b0;
            have_cat_q   <= 1'b0;
            frame_count  <= frame_count + 16'd1;
            state_q      <= COLLECT;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_seven_segment_sink.sv
// Bench for seven_segment_sink: three instances (dead-time 16, 0, 3) checked every cycle
// against a transaction-level model, plus directed literal checks.
module tb_seven_segment_sink;

`ifdef SEVEN_SEGMENT_SINK_SKIP_SAME_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk, rst;
  logic [31:0] an_w[3], cat_w[3];
  logic        an_stb[3], cat_stb[3], an_ack[3], cat_ack[3];
  logic [7:0]  an_pins[3], cat_pins[3];
  logic [15:0] fc[3];

  int total = 0;
  int bad = 0;

  // model state
  bit          m_have_an[3], m_have_cat[3];
  logic [7:0]  m_an[3], m_cat[3], m_pan[3], m_pcat[3];
  int          m_blank[3];
  logic [15:0] m_fc[3];

  seven_segment_sink #(.DEADTIME_CYCLES(16)) u0 (
    .clk(clk), .rst(rst),
    .input_annode(an_w[0]), .input_annode_stb(an_stb[0]), .input_annode_ack(an_ack[0]),
    .input_cathode(cat_w[0]), .input_cathode_stb(cat_stb[0]), .input_cathode_ack(cat_ack[0]),
    .annode_pins(an_pins[0]), .cathode_pins(cat_pins[0]), .frame_count(fc[0]));

  seven_segment_sink #(.DEADTIME_CYCLES(0)) u1 (
    .clk(clk), .rst(rst),
    .input_annode(an_w[1]), .input_annode_stb(an_stb[1]), .input_annode_ack(an_ack[1]),
    .input_cathode(cat_w[1]), .input_cathode_stb(cat_stb[1]), .input_cathode_ack(cat_ack[1]),
    .annode_pins(an_pins[1]), .cathode_pins(cat_pins[1]), .frame_count(fc[1]));

  seven_segment_sink #(.DEADTIME_CYCLES(3)) u2 (
    .clk(clk), .rst(rst),
    .input_annode(an_w[2]), .input_annode_stb(an_stb[2]), .input_annode_ack(an_ack[2]),
    .input_cathode(cat_w[2]), .input_cathode_stb(cat_stb[2]), .input_cathode_ack(cat_ack[2]),
    .annode_pins(an_pins[2]), .cathode_pins(cat_pins[2]), .frame_count(fc[2]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int dt_of(int i);
    return (i == 0) ? 16 : ((i == 1) ? 0 : 3);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset(int i);
    m_have_an[i] = 0; m_have_cat[i] = 0; m_blank[i] = 0;
    m_an[i] = '0; m_cat[i] = '0;
    m_pan[i] = 8'hFF; m_pcat[i] = 8'hFF; m_fc[i] = '0;
  endtask

  task automatic model_apply(int i);
    m_pan[i] = m_an[i]; m_pcat[i] = m_cat[i];
    m_have_an[i] = 0; m_have_cat[i] = 0;
    m_fc[i] = m_fc[i] + 16'd1;
  endtask

  // Advance the model over the coming rising edge, given the inputs now driven.
  task automatic model_step(int i);
    if (!rst) model_reset(i);
    else if (m_blank[i] > 0) begin
      m_blank[i]--;
      if (m_blank[i] == 0) model_apply(i);
    end else begin
      if (an_stb[i] && !m_have_an[i]) begin m_have_an[i] = 1; m_an[i] = an_w[i][7:0]; end
      if (cat_stb[i] && !m_have_cat[i]) begin m_have_cat[i] = 1; m_cat[i] = cat_w[i][7:0]; end
      if (m_have_an[i] && m_have_cat[i]) begin
        if (SKIP && m_an[i] == m_pan[i] && m_cat[i] == m_pcat[i]) begin
          m_have_an[i] = 0; m_have_cat[i] = 0;
        end else if (dt_of(i) == 0) model_apply(i);
        else begin
          m_pan[i] = 8'hFF; m_pcat[i] = 8'hFF; m_blank[i] = dt_of(i);
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("u%0d.annode_pins", i), 32'(an_pins[i]), 32'(m_pan[i]));
      check($sformatf("u%0d.cathode_pins", i), 32'(cat_pins[i]), 32'(m_pcat[i]));
      check($sformatf("u%0d.frame_count", i), 32'(fc[i]), 32'(m_fc[i]));
      check($sformatf("u%0d.annode_ack", i), 32'(an_ack[i]),
            32'(rst && m_blank[i] == 0 && !m_have_an[i]));
      check($sformatf("u%0d.cathode_ack", i), 32'(cat_ack[i]),
            32'(rst && m_blank[i] == 0 && !m_have_cat[i]));
    end
  endtask

  task automatic tick();
    for (int i = 0; i < 3; i++) model_step(i);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    for (int i = 0; i < 3; i++) begin
      an_stb[i] = 0; cat_stb[i] = 0; an_w[i] = '0; cat_w[i] = '0;
    end
  endtask

  // Present a pair to u0 on one edge, then drop both strobes.
  task automatic send0(logic [31:0] a, logic [31:0] c);
    an_w[0] = a; cat_w[0] = c; an_stb[0] = 1; cat_stb[0] = 1;
    tick();
    an_stb[0] = 0; cat_stb[0] = 0;
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    for (int i = 0; i < 3; i++) model_reset(i);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    compare_all();
    check("reset.annode_pins", 32'(an_pins[0]), 32'hFF);
    rst = 1'b1;
    #1;
    check("rel.annode_ack", 32'(an_ack[0]), 32'h1);
    check("rel.cathode_ack", 32'(cat_ack[0]), 32'h1);
    check("rel.frame_count", 32'(fc[0]), 32'h0);
    @(negedge clk);

    // Same-edge pair on u0; simultaneous pair on the zero-dead-time u1.
    an_w[1] = 32'hA5; cat_w[1] = 32'h5A; an_stb[1] = 1; cat_stb[1] = 1;
    send0(32'hFE, 32'hC0);
    an_stb[1] = 0; cat_stb[1] = 0;
    check("t2.ack_drop", 32'(an_ack[0]), 32'h0);
    check("t2.blank_an", 32'(an_pins[0]), 32'hFF);
    check("dt0.apply_an", 32'(an_pins[1]), 32'hA5);
    check("dt0.apply_cat", 32'(cat_pins[1]), 32'h5A);
    check("dt0.fc", 32'(fc[1]), 32'h1);
    for (int k = 0; k < 15; k++) begin
      tick();
      check("t2.blank_cat", 32'(cat_pins[0]), 32'hFF);
    end
    tick();
    check("t2.apply_an", 32'(an_pins[0]), 32'hFE);
    check("t2.apply_cat", 32'(cat_pins[0]), 32'hC0);
    check("t2.fc", 32'(fc[0]), 32'h1);
    check("t2.ack_back", 32'(cat_ack[0]), 32'h1);

    // Identical pair again on u1 (dead-time 0).
    an_stb[1] = 1; cat_stb[1] = 1;
    tick();
    an_stb[1] = 0; cat_stb[1] = 0;
    check("dt0.same_fc", 32'(fc[1]), SKIP ? 32'h1 : 32'h2);

    // Annode first, cathode held back, second annode word stalled.
    an_w[0] = 32'hFD; an_stb[0] = 1;
    tick();
    an_w[0] = 32'h11;
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t3.stall_ack", 32'(an_ack[0]), 32'h0);
      check("t3.hold_an", 32'(an_pins[0]), 32'hFE);
    end
    cat_w[0] = 32'hF9; cat_stb[0] = 1;
    tick();
    cat_stb[0] = 0;
    repeat (16) tick();
    check("t3.apply_an", 32'(an_pins[0]), 32'hFD);
    check("t3.apply_cat", 32'(cat_pins[0]), 32'hF9);
    check("t3.ack_after", 32'(an_ack[0]), 32'h1);
    tick();
    an_stb[0] = 0;
    check("t3.second_taken", 32'(an_ack[0]), 32'h0);
    cat_w[0] = 32'hF9; cat_stb[0] = 1;
    tick();
    cat_stb[0] = 0;
    repeat (16) tick();
    check("t3.second_an", 32'(an_pins[0]), 32'h11);

    // Upper word bits ignored.
    send0(32'hFFFFFF7F, 32'h12345680);
    repeat (16) tick();
    check("t4.an_low", 32'(an_pins[0]), 32'h7F);
    check("t4.cat_low", 32'(cat_pins[0]), 32'h80);
    check("t4.fc", 32'(fc[0]), 32'h4);

    // Reset in the middle of blanking.
    send0(32'h0F, 32'h3F);
    repeat (5) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) model_reset(i);
    #1;
    check("t5.rst_an", 32'(an_pins[0]), 32'hFF);
    check("t5.rst_fc", 32'(fc[0]), 32'h0);
    check("t5.rst_ack", 32'(an_ack[0]), 32'h0);
    tick();
    rst = 1'b1;
    send0(32'h0F, 32'h3F);
    repeat (16) tick();
    check("t5.apply_an", 32'(an_pins[0]), 32'h0F);
    check("t5.fc", 32'(fc[0]), 32'h1);

    // Identical pair on u0.
    send0(32'h0F, 32'h3F);
    check("t6.same_an", 32'(an_pins[0]), SKIP ? 32'h0F : 32'hFF);
    repeat (16) tick();
    check("t6.same_fc", 32'(fc[0]), SKIP ? 32'h1 : 32'h2);
    check("t6.same_cat", 32'(cat_pins[0]), 32'h3F);

    // Random traffic on all instances, with occasional resets.
    for (int n = 0; n < 4000; n++) begin
      for (int i = 0; i < 3; i++) begin
        an_stb[i]  = ($urandom_range(2) != 0);
        cat_stb[i] = ($urandom_range(2) != 0);
        an_w[i]  = ($urandom_range(3) == 0) ? {$urandom, m_pan[i]} >> 0 : $urandom;
        cat_w[i] = ($urandom_range(3) == 0) ? {24'($urandom), m_pcat[i]} : $urandom;
        if ($urandom_range(3) == 0) an_w[i] = {24'($urandom), m_pan[i]};
      end
      rst = ($urandom_range(499) != 0);
      if (!rst) for (int i = 0; i < 3; i++) model_reset(i);
      tick();
      rst = 1'b1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
